// File: rtl/gray_monitor.sv
// gray_monitor: receive-side checker for a 3-bit Gray-coded counter.
// Converts each accepted code to binary, verifies that every change is the
// single legal forward step, pulses Step/Wrap, counts wraps (saturating) and
// latches a sticky Error on any illegal transition.
module gray_monitor #(
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [2:0]        In,
  output logic [2:0]        Bin,
  output logic              Locked,
  output logic              Step,
  output logic              Wrap,
  output logic [WRAP_W-1:0] WrapCount,
  output logic              Error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  state_t            state_q, state_d;
  logic [2:0]        bin_q, bin_d;
  logic              locked_q, locked_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              error_q, error_d;

  logic [2:0] in_bin;
  logic [2:0] bin_inc;

  // Gray-to-binary conversion of the incoming code and the expected next value.
  always_comb begin
    in_bin[2] = In[2];
    in_bin[1] = In[2] ^ In[1];
    in_bin[0] = In[2] ^ In[1] ^ In[0];
    bin_inc   = bin_q + 3'd1;
  end

  // Next-state and next-output decision for the tracking state machine.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; without this the tool infers a latch instead of plain logic.
    state_d    = state_q;
    bin_d      = bin_q;
    locked_d   = locked_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    error_d    = error_q;

    if (Valid) begin
      unique case (state_q)
        IDLE: begin
          // Any starting code is accepted as the reference point.
          bin_d    = in_bin;
          locked_d = 1'b1;
          state_d  = TRACK;
        end
        TRACK: begin
          if (in_bin == bin_q) begin
            // Repeated code: legal, nothing to report.
          end else if (in_bin == bin_inc) begin
            bin_d  = in_bin;
            step_d = 1'b1;
            if (bin_q == 3'd7) begin
              wrap_d = 1'b1;
              if (wrap_cnt_q != WRAP_MAX) begin
                wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
              end
            end
          end else begin
            // Backward step, skip or multi-bit change: keep last good value.
            error_d = 1'b1;
            state_d = FAULT;
          end
        end
        FAULT: begin
          // Frozen until reset.
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; synchronous reset dominates everything.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      state_q    <= IDLE;
      bin_q      <= 3'd0;
      locked_q   <= 1'b0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      locked_q   <= locked_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
      error_q    <= error_d;
    end
  end

  assign Bin       = bin_q;
  assign Locked    = locked_q;
  assign Step      = step_q;
  assign Wrap      = wrap_q;
  assign WrapCount = wrap_cnt_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_gray_monitor.sv
// tb_gray_monitor: drives two gray_monitor instances (WRAP_W=8 and WRAP_W=2)
// with the same directed stimulus; a table-based reference model pushes the
// expected outputs into a scoreboard queue, popped and compared after each edge.
module tb_gray_monitor;

  logic       Clk;
  logic       Reset;
  logic       Valid;
  logic [2:0] In;

  logic [2:0] bin8, bin2;
  logic       locked8, locked2, step8, step2, wrap8, wrap2, err8, err2;
  logic [7:0] wc8;
  logic [1:0] wc2;

  gray_monitor #(.WRAP_W(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .In(In),
    .Bin(bin8), .Locked(locked8), .Step(step8), .Wrap(wrap8),
    .WrapCount(wc8), .Error(err8)
  );

  gray_monitor #(.WRAP_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .In(In),
    .Bin(bin2), .Locked(locked2), .Step(step2), .Wrap(wrap2),
    .WrapCount(wc2), .Error(err2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int bin;
    int locked;
    int step;
    int wrap;
    int wc8;
    int wc2;
    int err;
  } exp_t;

  exp_t sb_q[$];

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Counter order of the Gray codes; position in this table is the binary value.
  logic [2:0] gseq [8];

  // Reference model state
  int m_state;   // 0 idle, 1 track, 2 fault
  int m_bin, m_locked, m_wc8, m_wc2, m_err;

  function automatic int pos_of(input logic [2:0] g);
    int p;
    p = -1;
    for (int k = 0; k < 8; k++) if (gseq[k] == g) p = k;
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Drive one cycle, predict its outputs, then compare after the edge.
  task automatic cycle(input logic r, input logic v, input logic [2:0] g);
    exp_t e;
    int   p;
    Reset = r;
    Valid = v;
    In    = g;
    e = '{bin: m_bin, locked: m_locked, step: 0, wrap: 0,
          wc8: m_wc8, wc2: m_wc2, err: m_err};
    if (r) begin
      m_state = 0; m_bin = 0; m_locked = 0; m_wc8 = 0; m_wc2 = 0; m_err = 0;
      e = '{bin: 0, locked: 0, step: 0, wrap: 0, wc8: 0, wc2: 0, err: 0};
    end else if (v) begin
      p = pos_of(g);
      if (m_state == 0) begin
        m_bin = p; m_locked = 1; m_state = 1;
      end else if (m_state == 1) begin
        if (p == m_bin) begin
        end else if (p == (m_bin + 1) % 8) begin
          e.step = 1;
          if (p == 0) begin
            e.wrap = 1;
            if (m_wc8 < 255) m_wc8++;
            if (m_wc2 < 3)   m_wc2++;
          end
          m_bin = p;
        end else begin
          m_err = 1; m_state = 2;
        end
      end
      e.bin = m_bin; e.locked = m_locked; e.wc8 = m_wc8; e.wc2 = m_wc2; e.err = m_err;
    end
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    check("bin8",    bin8,    e.bin);
    check("locked8", locked8, e.locked);
    check("step8",   step8,   e.step);
    check("wrap8",   wrap8,   e.wrap);
    check("wc8",     wc8,     e.wc8);
    check("err8",    err8,    e.err);
    check("bin2",    bin2,    e.bin);
    check("step2",   step2,   e.step);
    check("wrap2",   wrap2,   e.wrap);
    check("wc2",     wc2,     e.wc2);
    check("err2",    err2,    e.err);
    check("locked2", locked2, e.locked);
  endtask

  initial begin
    gseq[0] = 3'b000; gseq[1] = 3'b001; gseq[2] = 3'b011; gseq[3] = 3'b010;
    gseq[4] = 3'b110; gseq[5] = 3'b111; gseq[6] = 3'b101; gseq[7] = 3'b100;
    m_state = 0; m_bin = 0; m_locked = 0; m_wc8 = 0; m_wc2 = 0; m_err = 0;
    Reset = 1'b1; Valid = 1'b0; In = 3'b000;

    // Reset state
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b1, 1'b1, 3'b111);

    // Full forward sequence with one wrap
    cycle(1'b0, 1'b1, 3'b000);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, gseq[i % 8]);
    check("seq_wrapcount", wc8, 32'd1);
    check("seq_bin_end",   bin8, 32'd0);

    // Lock on 110, repeats, then Valid low with a different code
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b110);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 3'b110);
    cycle(1'b0, 1'b0, 3'b000);
    cycle(1'b0, 1'b0, 3'b000);
    check("hold_bin", bin8, 32'd4);
    // Valid gaps in the middle of legal stepping
    cycle(1'b0, 1'b1, 3'b111);
    cycle(1'b0, 1'b0, 3'b010);
    cycle(1'b0, 1'b1, 3'b101);

    // Lock on 011, backward to 001, then legal codes are ignored
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b011);
    cycle(1'b0, 1'b1, 3'b001);
    check("back_err", err8, 32'd1);
    check("back_bin", bin8, 32'd2);
    cycle(1'b0, 1'b1, 3'b010);
    cycle(1'b0, 1'b1, 3'b110);
    cycle(1'b0, 1'b0, 3'b111);

    // Lock on 000, skip to 011, then reset with Valid high
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b000);
    cycle(1'b0, 1'b1, 3'b011);
    check("skip_bin", bin8, 32'd0);
    cycle(1'b1, 1'b1, 3'b001);
    check("fault_reset_err", err8, 32'd0);
    // Multi-bit jump also faults
    cycle(1'b0, 1'b1, 3'b001);
    cycle(1'b0, 1'b1, 3'b100);

    // Four complete cycles: WRAP_W=2 saturates at 3, WRAP_W=8 reaches 4
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b000);
    for (int i = 1; i <= 32; i++) cycle(1'b0, 1'b1, gseq[i % 8]);
    check("sat_wc2", wc2, 32'd3);
    check("sat_wc8", wc8, 32'd4);

    // Reset arriving together with a 100->000 step
    cycle(1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 3'b000);
    for (int i = 1; i < 8; i++) cycle(1'b0, 1'b1, gseq[i]);
    cycle(1'b1, 1'b1, 3'b000);
    check("rst_wrap_wrap", wrap8, 32'd0);
    check("rst_wrap_wc",   wc8,   32'd0);
    check("rst_wrap_lock", locked8, 32'd0);
    cycle(1'b0, 1'b0, 3'b000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gray_monitor.md
# gray_monitor

Receive-side companion to the 3-bit Gray-code counter: samples a 3-bit Gray-coded value each enabled cycle, converts it to binary, checks that every change is the single legal forward step of the counter sequence, and counts wrap-arounds. Sits on the consumer side of any Gray-counted path, such as a position or sequence indicator. It gives downstream logic a binary view plus step, wrap and error indications.

## Interface
- WRAP_W, 8, width of the wrap counter (≥1)

- Clk  input  1  clock; all state updates on posedge
- Reset  input  1  synchronous, active-high; dominates all other inputs
- Valid  input  1  In is sampled this cycle when high
- In  input  3  Gray-coded value (sequence 000,001,011,010,110,111,101,100,000…)
- Bin  output  3  registered binary of last accepted code
- Locked  output  1  high once a first code has been accepted
- Step  output  1  one-cycle pulse: legal forward step accepted
- Wrap  output  1  one-cycle pulse: step 100→000 accepted (Step also high)
- WrapCount  output  WRAP_W  number of wraps, saturates at all-ones
- Error  output  1  sticky: illegal transition detected

## Operation
- Conversion: b2=g2, b1=g2^g1, b0=b1^g0. The counter order then maps to binary 0..7, so the legal next code is (Bin+1) mod 8.
- States: IDLE, TRACK, FAULT.
- IDLE, Valid=1: Bin←bin(In), Locked←1, go TRACK. No Step, no Wrap. Any starting code is accepted.
- TRACK, Valid=1:
  - bin(In)==Bin: hold, no pulses (repeats are legal).
  - bin(In)==Bin+1 mod 8: Bin←bin(In), Step=1.
  - If additionally Bin==7 and bin(In)==0: Wrap=1, WrapCount←WrapCount+1, saturating at 2^WRAP_W−1.
  - Any other value (backward step, multi-bit change, skip): Error←1, go FAULT. Bin keeps the last good value, no Step.
- FAULT: all inputs ignored; Error, Bin, WrapCount and Locked hold until Reset.
- Valid=0 in any state: no state change; Step=Wrap=0.
- Step and Wrap are low in every cycle that does not accept a forward step.

## Timing
- Reset (sampled at posedge): state=IDLE, Bin=000, Locked=0, Step=0, Wrap=0, WrapCount=0, Error=0.
- Reset mid-operation (any state, including FAULT) returns to these values at the next edge, regardless of Valid/In.
- Latency is 1 cycle: In sampled at edge N appears on Bin/Step/Wrap/Error after edge N.
- Step/Wrap are registered pulses, high for exactly one cycle per accepted step. Back-to-back legal steps give consecutive pulses.
- Error rises in the cycle after the offending sample and stays high.
- WrapCount updates in the same cycle that Wrap is high; at saturation Wrap still pulses, count unchanged.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then Valid=1 with In=000 held 1 cycle, then the full sequence 001,011,010,110,111,101,100,000 → Locked=1, Step pulses 8 times, Bin steps through 1..7,0, Wrap=1 only on the 000 cycle, WrapCount=1, Error=0.
- Lock on 110, then hold 110 for 3 cycles with Valid=1, then Valid=0 with In=000 → Bin=4 throughout, no Step, Error=0.
- Lock on 011, then apply 001 (backward) → Error=1 next cycle, Bin=2, no Step. Subsequent legal codes are ignored and Error stays 1.
- Lock on 000, then apply 011 (skip) → Error=1, Bin=0. Assert Reset with Valid=1 → all outputs zero, state IDLE.
- WRAP_W=2: run 4 complete cycles → WrapCount=3 after the third wrap, Wrap still pulses on the fourth, count stays 3.
- Assert Reset in the cycle a 100→000 step arrives → no Wrap, WrapCount=0, Locked=0.
